// File: rtl/light_show_sequencer.sv
// Light-show sequencer for a 10-LED bar: slow thermometer fill, repeated fast one-hot
// chase, then an all-LED blink, each phase stepping on its own timebase period.
module light_show_sequencer #(
  parameter int unsigned TICK_SLOW = 100000000,
  parameter int unsigned TICK_FAST = 5000000,
  parameter int unsigned TICK_HOLD = 50000000,
  parameter int unsigned REPS      = 4,
  parameter int unsigned BLINKS    = 3,
  parameter int unsigned CW        = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startBtn,
  output logic [9:0] ledPattern,
  output logic [2:0] state,
  output logic [3:0] repCount,
  output logic       running,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSlow = 3'd1,
    StFast = 3'd2,
    StHold = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam int unsigned BW        = $clog2(2 * BLINKS) + 1;
  localparam logic [CW-1:0] LastSlow  = CW'(TICK_SLOW - 1);
  localparam logic [CW-1:0] LastFast  = CW'(TICK_FAST - 1);
  localparam logic [CW-1:0] LastHold  = CW'(TICK_HOLD - 1);
  localparam logic [BW-1:0] LastBlink = BW'(2 * BLINKS - 1);
  localparam logic [3:0]    Reps      = 4'(REPS);

  state_e        state_q, state_d;
  logic [9:0]    led_q, led_d;
  logic [3:0]    rep_q, rep_d;
  logic [3:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_cnt;
  logic          sync1_q, sync2_q, prev_q;
  logic          start_pulse;
  logic          tick;

  // Falling edge of the synchronised, active-low button.
  assign start_pulse = prev_q & ~sync2_q;

  always_comb begin
    case (state_q)
      StSlow:  last_cnt = LastSlow;
      StFast:  last_cnt = LastFast;
      default: last_cnt = LastHold;
    endcase
  end

  assign tick = (cnt_q == last_cnt);

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    blink_d = blink_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_pulse) begin
          state_d = StSlow;
          led_d   = 10'b0000000001;
          idx_d   = 4'd0;
        end
      end
      StSlow: begin
        if (tick) begin
          if (idx_q != 4'd9) begin
            idx_d = idx_q + 4'd1;
            led_d = {led_q[8:0], 1'b1};
          end else begin
            state_d = StFast;
            idx_d   = 4'd0;
            led_d   = 10'b0000000001;
            rep_d   = Reps;
          end
        end
      end
      StFast: begin
        if (tick) begin
          if (idx_q != 4'd9) begin
            idx_d = idx_q + 4'd1;
            led_d = {led_q[8:0], 1'b0};
          end else if (rep_q > 4'd1) begin
            rep_d = rep_q - 4'd1;
            idx_d = 4'd0;
            led_d = 10'b0000000001;
          end else begin
            state_d = StHold;
            rep_d   = 4'd0;
            led_d   = 10'h3FF;
            blink_d = '0;
          end
        end
      end
      StHold: begin
        if (tick) begin
          if (blink_q < LastBlink) begin
            led_d   = ~led_q;
            blink_d = blink_q + 1'b1;
          end else begin
            state_d = StDone;
            led_d   = 10'h000;
          end
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = 10'h000;
        rep_d   = 4'd0;
        idx_d   = 4'd0;
        blink_d = '0;
      end
    endcase
  end

  // Timebase restarts on every phase change so each phase's first step is a full period.
  always_comb begin
    if ((state_d != state_q) || (state_q == StIdle) || (state_q == StDone)) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      led_q   <= 10'h000;
      rep_q   <= 4'd0;
      idx_q   <= 4'd0;
      blink_q <= '0;
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      sync1_q <= startBtn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign ledPattern = led_q;
  assign state      = state_q;
  assign repCount   = rep_q;
  assign running    = (state_q == StSlow) || (state_q == StFast) || (state_q == StHold);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_light_show_sequencer.sv
// Scoreboard bench for light_show_sequencer: expected output changes (value and hold length)
// are queued by the stimulus; a negedge monitor pops one entry per observed output change.
module tb_light_show_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       startBtn;
  logic [9:0] ledPattern;
  logic [2:0] state;
  logic [3:0] repCount;
  logic       running;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] st;
    logic [9:0] led;
    logic [3:0] rep;
    logic       run;
    logic       dn;
    int         hold;
  } exp_t;

  exp_t sb[$];

  light_show_sequencer #(
    .TICK_SLOW(4),
    .TICK_FAST(2),
    .TICK_HOLD(3),
    .REPS(2),
    .BLINKS(2),
    .CW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startBtn(startBtn),
    .ledPattern(ledPattern),
    .state(state),
    .repCount(repCount),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: every change in the output tuple consumes one scoreboard entry.
  int          cyc = 0;
  int          last_cyc = 0;
  logic [18:0] last_tuple = '0;
  int          seq_no = 0;

  always @(negedge clk) begin
    logic [18:0] cur;
    logic [18:0] want;
    exp_t        e;
    cyc = cyc + 1;
    cur = {state, ledPattern, repCount, running, done};
    if (cur !== last_tuple) begin
      seq_no = seq_no + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_change #%0d: got state=%0d led=%03h rep=%0d run=%0b done=%0b, none expected",
                 seq_no, state, ledPattern, repCount, running, done);
      end else begin
        e = sb.pop_front();
        want = {e.st, e.led, e.rep, e.run, e.dn};
        if (cur !== want) begin
          errors = errors + 1;
          $display("FAIL seq_value #%0d: got state=%0d led=%03h rep=%0d run=%0b done=%0b, want state=%0d led=%03h rep=%0d run=%0b done=%0b",
                   seq_no, state, ledPattern, repCount, running, done,
                   e.st, e.led, e.rep, e.run, e.dn);
        end
        if (e.hold != 0) begin
          checks = checks + 1;
          if ((cyc - last_cyc) != e.hold) begin
            errors = errors + 1;
            $display("FAIL seq_hold #%0d: previous value held %0d cycles, want %0d",
                     seq_no, cyc - last_cyc, e.hold);
          end
        end
      end
      last_tuple = cur;
      last_cyc   = cyc;
    end
  end

  task automatic push(input logic [2:0] st, input logic [9:0] led, input logic [3:0] rep,
                      input int hold);
    exp_t e;
    e.st   = st;
    e.led  = led;
    e.rep  = rep;
    e.run  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    e.dn   = (st == 3'd4);
    e.hold = hold;
    sb.push_back(e);
  endtask

  // Expected output changes of one run with TICK 4/2/3, REPS=2, BLINKS=2.
  task automatic push_run(input bit to_done);
    logic [9:0] led;
    push(3'd1, 10'h001, 4'd0, 0);
    led = 10'h001;
    for (int i = 1; i < 10; i++) begin
      led = {led[8:0], 1'b1};
      push(3'd1, led, 4'd0, 4);
    end
    for (int r = 2; r >= 1; r--) begin
      push(3'd2, 10'h001, 4'(r), (r == 2) ? 4 : 2);
      led = 10'h001;
      for (int i = 1; i < 10; i++) begin
        led = {led[8:0], 1'b0};
        push(3'd2, led, 4'(r), 2);
      end
    end
    push(3'd3, 10'h3FF, 4'd0, 2);
    if (to_done) begin
      push(3'd3, 10'h000, 4'd0, 3);
      push(3'd3, 10'h3FF, 4'd0, 3);
      push(3'd3, 10'h000, 4'd0, 3);
      push(3'd4, 10'h000, 4'd0, 3);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic drain(input string nm, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s: %0d expected changes never seen, want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] st, input int max_cycles);
    int n = 0;
    while (state !== st && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, int'(state), int'(st));
  endtask

  initial begin
    reset    = 1'b1;
    startBtn = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1. Reset values and start detect latency.
    chk("reset_state", int'(state), 0);
    chk("reset_led", int'(ledPattern), 0);
    chk("reset_rep", int'(repCount), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_done", int'(done), 0);
    push_run(1'b1);
    @(posedge clk);
    #1 startBtn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("idle_after_2_edges", int'(state), 0);
    chk("led_after_2_edges", int'(ledPattern), 0);
    @(posedge clk);
    #1;
    chk("slow_on_3rd_edge", int'(state), 1);
    chk("led_on_3rd_edge", int'(ledPattern), 10'h001);
    repeat (17) @(posedge clk);
    #1 startBtn = 1'b1;

    // 2-4. Full run to DONE, checked through the scoreboard.
    drain("run1_complete", 200);
    #1;
    chk("done_state", int'(state), 4);
    chk("done_flag", int'(done), 1);
    chk("done_running", int'(running), 0);
    chk("done_led", int'(ledPattern), 0);

    // 4-5. Restart from DONE; press during FAST must not disturb the run.
    push_run(1'b1);
    @(posedge clk);
    #1 startBtn = 1'b0;
    repeat (3) @(posedge clk);
    #1 startBtn = 1'b1;
    chk("restart_done_clear", int'(done), 0);
    wait_state("reach_fast", 3'd2, 100);
    repeat (5) @(posedge clk);
    #1 startBtn = 1'b0;
    repeat (6) @(posedge clk);
    #1 startBtn = 1'b1;
    drain("run2_complete", 200);

    // 6. Reset mid-HOLD with a button fall still in the synchroniser.
    push_run(1'b0);
    @(posedge clk);
    #1 startBtn = 1'b0;
    repeat (3) @(posedge clk);
    #1 startBtn = 1'b1;
    wait_state("reach_hold", 3'd3, 200);
    push(3'd0, 10'h000, 4'd0, 0);
    #1 startBtn = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrun_reset_state", int'(state), 0);
    chk("midrun_reset_led", int'(ledPattern), 0);
    chk("midrun_reset_rep", int'(repCount), 0);
    chk("midrun_reset_running", int'(running), 0);
    startBtn = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_reset", int'(state), 0);
    drain("reset_entry_seen", 5);

    push(3'd1, 10'h001, 4'd0, 0);
    #1 startBtn = 1'b0;
    drain("start_after_reset", 10);
    #1 startBtn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
